sha256_message_schedule: RTL and testbench

- Message-expansion stage directly upstream of the SHA-256 compression round logic.
- Loads one 512-bit padded block and supplies W[t] on w_out during the 64 round cycles. w_out connects straight to the compressor's per-round message input.
- Driven by the same top-level controller state and round index as the compressor, so both stages advance in lockstep.
- A 16-word sliding window generates W[16..63] on the fly; no 64-entry storage.

---
 rtl/sha256_message_schedule.sv | 125 ++++++++++++
 tb/tb_sha256_message_schedule.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule.
// Holds a 16-word sliding window over W[t]. Word 0 of the window is the
// current round's W[t], presented combinationally so the compressor can
// consume it in the same cycle. Each round cycle shifts the window and
// appends W[t+16], so W[16..63] are produced on the fly without 64-entry
// storage. The stage follows the shared controller state and round index,
// and records a sticky error if the external round index ever disagrees
// with its own count.
module sha256_message_schedule #(
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_in,
    input  logic [16*DATA_W-1:0]  block_in,
    input  logic [1:0]            FSM_state_in,
    input  logic [6:0]            round_in,
    output logic [DATA_W-1:0]     w_out,
    output logic                  valid_out,
    output logic                  sync_err_out
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ROUND0TO15  = 2'd1;
    localparam logic [1:0] ROUND16TO63 = 2'd2;
    localparam logic [1:0] ROUND64     = 2'd3;

    localparam logic [6:0] NUM_ROUNDS  = 7'd64;

    // Window, round counter, loaded flag and sticky sync error.
    logic [DATA_W-1:0] w_q [16];
    logic [DATA_W-1:0] w_d [16];
    logic [6:0]        cnt_q, cnt_d;
    logic              ld_q, ld_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] w_new;
    logic              is_round;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    // Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3.
    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10.
    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // W[t+16] from the current window (window word k holds W[t+k]); mod 2^32.
    assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    assign is_round = (FSM_state_in == ROUND0TO15) || (FSM_state_in == ROUND16TO63);

    // Outputs: current word straight from the window, valid only for a loaded block in rounds.
    always_comb begin
        w_out        = w_q[0];
        valid_out    = ld_q && is_round && (cnt_q < NUM_ROUNDS);
        sync_err_out = err_q;
    end

    // Next-state: load in IDLE, shift/expand in round states, drop the loaded flag in ROUND64.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end
        cnt_d = cnt_q;
        ld_d  = ld_q;
        err_d = err_q;

        case (FSM_state_in)
            IDLE: begin
                if (start_in) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[(15-i)*DATA_W +: DATA_W];
                    end
                    cnt_d = 7'd0;
                    ld_d  = 1'b1;
                    err_d = 1'b0;
                end
            end
            ROUND0TO15, ROUND16TO63: begin
                // Shift is unconditional; words past W[63] simply fall out unused.
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_new;
                if (cnt_q != NUM_ROUNDS) begin
                    cnt_d = cnt_q + 7'd1;
                end
                // Only a loaded block can be out of step with the controller.
                if (ld_q && (round_in != cnt_q)) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                ld_d = 1'b0;
            end
        endcase
    end

    // State registers; synchronous reset clears everything and abandons any block in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            cnt_q <= 7'd0;
            ld_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Testbench for sha256_message_schedule: directed scenarios plus a
// golden software schedule for random blocks.
module tb_sha256_message_schedule;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start_in;
    logic [511:0] block_in;
    logic [1:0]   FSM_state_in;
    logic [6:0]   round_in;
    logic [31:0]  w_out;
    logic         valid_out;
    logic         sync_err_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_w [0:79];

    sha256_message_schedule dut (
        .CLK          (CLK),
        .RST          (RST),
        .start_in     (start_in),
        .block_in     (block_in),
        .FSM_state_in (FSM_state_in),
        .round_in     (round_in),
        .w_out        (w_out),
        .valid_out    (valid_out),
        .sync_err_out (sync_err_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Standard SHA-256 schedule, extended to 80 words so the window contents
    // after the last round shift (W[64]) are known too.
    function automatic void gen_sched(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++)
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
        return b;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [511:0] b);
        FSM_state_in = 2'd0;
        start_in     = 1'b1;
        block_in     = b;
        tick();
        start_in     = 1'b0;
    endtask

    task automatic set_round(input int t, input int r);
        FSM_state_in = (t < 16) ? 2'd1 : 2'd2;
        round_in     = 7'(r);
    endtask

    task automatic test_reset();
        logic [511:0] abc;
        abc = {32'h61626380, 448'h0, 32'h00000018};
        RST = 1'b1; start_in = 1'b1; block_in = abc; FSM_state_in = 2'd0; round_in = 7'd0;
        tick();
        tick();
        RST = 1'b0; start_in = 1'b0; FSM_state_in = 2'd1;
        #1;
        n_tests++;
        if (w_out !== 32'h0) begin n_fail++; $display("FAIL reset_w_out: got %h want 00000000", w_out); end
        n_tests++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_tests++;
        if (sync_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b want 0", sync_err_out); end
        FSM_state_in = 2'd0;
        tick();
    endtask

    task automatic test_abc();
        logic [511:0] abc;
        logic [31:0]  want;
        int           vcnt;
        bit           chk;
        abc  = {32'h61626380, 448'h0, 32'h00000018};
        vcnt = 0;
        load(abc);
        for (int t = 0; t < 64; t++) begin
            set_round(t, t);
            #1;
            if (valid_out === 1'b1) vcnt++;
            chk = 1'b1;
            case (t)
                0:  want = 32'h61626380;
                15: want = 32'h00000018;
                16: want = 32'h61626380;
                17: want = 32'h000F0000;
                18: want = 32'h7DA86405;
                63: want = 32'h12B1EDEB;
                default: begin want = 32'h0; chk = 1'b0; end
            endcase
            if (chk) begin
                n_tests++;
                if (w_out !== want) begin n_fail++; $display("FAIL abc_w%0d: got %h want %h", t, w_out, want); end
            end
            tick();
        end
        FSM_state_in = 2'd3;
        #1;
        if (valid_out === 1'b1) vcnt++;
        n_tests++;
        if (sync_err_out !== 1'b0) begin n_fail++; $display("FAIL abc_sync_err: got %b want 0", sync_err_out); end
        tick();
        FSM_state_in = 2'd1;
        #1;
        if (valid_out === 1'b1) vcnt++;
        n_tests++;
        if (vcnt != 64) begin n_fail++; $display("FAIL abc_valid_cycles: got %0d want 64", vcnt); end
        FSM_state_in = 2'd0;
        tick();
    endtask

    task automatic test_random();
        logic [511:0] b;
        for (int it = 0; it < 200; it++) begin
            b = (it == 0) ? {512{1'b1}} : rand_block();
            gen_sched(b);
            load(b);
            for (int t = 0; t < 64; t++) begin
                set_round(t, t);
                #1;
                n_tests++;
                if (w_out !== exp_w[t] || valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_it%0d_w%0d: got %h/v%b want %h/v1", it, t, w_out, valid_out, exp_w[t]);
                end
                tick();
            end
            FSM_state_in = 2'd3;
            tick();
        end
        n_tests++;
        if (sync_err_out !== 1'b0) begin n_fail++; $display("FAIL rand_sync_err: got %b want 0", sync_err_out); end
    endtask

    task automatic test_sync_err();
        logic [511:0] b;
        b = rand_block();
        gen_sched(b);
        load(b);
        for (int t = 0; t < 64; t++) begin
            set_round(t, (t <= 20) ? t : t + 1);
            #1;
            if (t == 21) begin
                n_tests++;
                if (sync_err_out !== 1'b0) begin n_fail++; $display("FAIL sync_before: got %b want 0", sync_err_out); end
            end
            if (t == 22) begin
                n_tests++;
                if (sync_err_out !== 1'b1) begin n_fail++; $display("FAIL sync_rise: got %b want 1", sync_err_out); end
                n_tests++;
                if (w_out !== exp_w[22]) begin n_fail++; $display("FAIL sync_w22: got %h want %h", w_out, exp_w[22]); end
            end
            tick();
        end
        FSM_state_in = 2'd3;
        #1;
        n_tests++;
        if (sync_err_out !== 1'b1) begin n_fail++; $display("FAIL sync_round64: got %b want 1", sync_err_out); end
        tick();
        FSM_state_in = 2'd0;
        #1;
        n_tests++;
        if (sync_err_out !== 1'b1) begin n_fail++; $display("FAIL sync_idle: got %b want 1", sync_err_out); end
        tick();
        load(rand_block());
        #1;
        n_tests++;
        if (sync_err_out !== 1'b0) begin n_fail++; $display("FAIL sync_clear: got %b want 0", sync_err_out); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] a, b;
        a = rand_block();
        b = rand_block();
        load(a);
        for (int t = 0; t < 30; t++) begin
            set_round(t, t);
            tick();
        end
        set_round(30, 30);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        FSM_state_in = 2'd0;
        #1;
        n_tests++;
        if (w_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_w_out: got %h want 00000000", w_out); end
        n_tests++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_out); end
        tick();
        set_round(31, 31);
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || sync_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_unloaded_round: got v%b e%b want v0 e0", valid_out, sync_err_out);
        end
        tick();
        gen_sched(b);
        load(b);
        for (int t = 0; t < 3; t++) begin
            set_round(t, t);
            #1;
            n_tests++;
            if (w_out !== exp_w[t] || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_new_w%0d: got %h/v%b want %h/v1", t, w_out, valid_out, exp_w[t]);
            end
            tick();
        end
        FSM_state_in = 2'd3;
        tick();
    endtask

    task automatic test_start_ignored();
        logic [511:0] a, b;
        a = rand_block();
        b = rand_block();
        gen_sched(a);
        load(a);
        for (int t = 0; t < 64; t++) begin
            set_round(t, t);
            start_in = (t == 20);
            if (t == 20) block_in = b;
            #1;
            n_tests++;
            if (w_out !== exp_w[t]) begin n_fail++; $display("FAIL ignstart_w%0d: got %h want %h", t, w_out, exp_w[t]); end
            tick();
        end
        FSM_state_in = 2'd3;
        start_in = 1'b1;
        #1;
        n_tests++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ignstart_r64_valid: got %b want 0", valid_out); end
        tick();
        start_in = 1'b0;
        FSM_state_in = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (w_out !== exp_w[64] || valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL ignstart_idle_hold%0d: got %h/v%b want %h/v0", k, w_out, valid_out, exp_w[64]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        a = rand_block();
        b = rand_block();
        gen_sched(a);
        load(a);
        for (int t = 0; t < 64; t++) begin
            set_round(t, t);
            #1;
            n_tests++;
            if (w_out !== exp_w[t]) begin n_fail++; $display("FAIL b2b_a_w%0d: got %h want %h", t, w_out, exp_w[t]); end
            tick();
        end
        FSM_state_in = 2'd3;
        tick();
        gen_sched(b);
        load(b);
        for (int t = 0; t < 64; t++) begin
            set_round(t, t);
            #1;
            n_tests++;
            if (w_out !== exp_w[t] || valid_out !== 1'b1 || sync_err_out !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_b_w%0d: got %h/v%b/e%b want %h/v1/e0", t, w_out, valid_out, sync_err_out, exp_w[t]);
            end
            tick();
        end
        FSM_state_in = 2'd3;
        tick();
        FSM_state_in = 2'd0;
        tick();
    endtask

    initial begin
        RST = 1'b1; start_in = 1'b0; block_in = '0; FSM_state_in = 2'd0; round_in = 7'd0;
        tick();
        test_reset();
        test_abc();
        test_random();
        test_sync_err();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
